// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and address maps for the uart_rx receive controller.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POLL    = 2'd1,
        ST_RD_PAR  = 2'd2,
        ST_RD_DATA = 2'd3
    } rx_state_e;

    localparam logic [31:0] REG_DATA   = 32'h00;
    localparam logic [31:0] REG_STATUS = 32'h04;
    localparam logic [31:0] REG_COUNT  = 32'h08;
    localparam logic [31:0] REG_CTRL   = 32'h0C;
    localparam logic [31:0] REG_THRESH = 32'h10;

    localparam logic [31:0] RX_REG_DATA   = 32'h00;
    localparam logic [31:0] RX_REG_STATUS = 32'h04;
    localparam logic [31:0] RX_REG_PARITY = 32'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_PAR_ERR  = 3;

endpackage

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; head is visible on data_o (first-word fall-through).
// Latency: a push is visible in count_o/data_o the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; flush beats both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries behind the pointers are ever read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: polls uart_rx, drains bytes into a FIFO, register window + irq; parity via UART_RX_CTRL_PARITY_EN.
// Latency: valid-detect to push 2 cycles (3 with parity); rdata_o and irq_o registered, one cycle.
// Backpressure: none toward uart_rx; a byte arriving at a full FIFO is dropped and flags overrun.
module uart_rx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic        rx_req_o,
    output logic        rx_we_o,
    output logic [31:0] rx_addr_o,
    input  logic [31:0] rx_data_i
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
`ifdef UART_RX_CTRL_PARITY_EN
    localparam rx_state_e FIRST_RD = ST_RD_PAR;
`else
    localparam rx_state_e FIRST_RD = ST_RD_DATA;
`endif

    rx_state_e     state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic          en_q, en_d, irq_en_q, irq_en_d;
    logic          ovr_q, ovr_d, perr_q, perr_d;
    logic [CW-1:0] thresh_q, thresh_d;
    logic          rd_en, wr_en, push, pop, flush;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_cnt;
    logic          unused_bits;

    assign rd_en       = req_i & ~we_i;
    assign wr_en       = req_i & we_i;
    assign push        = (state_q == ST_RD_DATA);
    assign pop         = rd_en & (addr_i == REG_DATA) & ~fifo_empty;
    assign flush       = wr_en & (addr_i == REG_CTRL) & wdata_i[CTRL_FLUSH];
    assign unused_bits = ^{rx_data_i[31:8], RX_REG_PARITY};

    assign rdata_o = rdata_q;
    assign irq_o   = irq_q;
    assign rx_we_o = 1'b0;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (rx_data_i[7:0]),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifo_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        rx_req_o  = 1'b1;
        rx_addr_o = RX_REG_STATUS;
        case (state_q)
            ST_IDLE: begin
                rx_req_o  = 1'b0;
                rx_addr_o = '0;
                if (en_q) state_d = ST_POLL;
            end
            ST_POLL: begin
                if (!en_q)             state_d = ST_IDLE;
                else if (rx_data_i[0]) state_d = FIRST_RD;
            end
`ifdef UART_RX_CTRL_PARITY_EN
            ST_RD_PAR: begin
                rx_addr_o = RX_REG_PARITY;
                state_d   = ST_RD_DATA;
            end
`endif
            ST_RD_DATA: begin
                // A disable mid-sequence only takes hold once the byte is in.
                rx_addr_o = RX_REG_DATA;
                state_d   = en_q ? ST_POLL : ST_IDLE;
            end
            default: begin
                rx_req_o  = 1'b0;
                rx_addr_o = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_CTRL_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (state_q == ST_RD_PAR) par_d = rx_data_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) par_q <= 1'b0;
        else         par_q <= par_d;
    end
`endif

    always_comb begin
        rdata_d  = rdata_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ovr_d    = ovr_q;
        perr_d   = perr_q;
        if (rd_en) begin
            rdata_d = '0;
            case (addr_i)
                REG_DATA:   rdata_d = fifo_empty ? '0 : {24'b0, fifo_dat};
                REG_STATUS: begin
                    rdata_d[STAT_EMPTY]   = fifo_empty;
                    rdata_d[STAT_FULL]    = fifo_full;
                    rdata_d[STAT_OVERRUN] = ovr_q;
                    rdata_d[STAT_PAR_ERR] = perr_q;
                end
                REG_COUNT:  rdata_d = 32'(fifo_cnt);
                REG_CTRL:   rdata_d = {30'b0, irq_en_q, en_q};
                REG_THRESH: rdata_d = 32'(thresh_q);
                default:    rdata_d = '0;
            endcase
        end
        if (wr_en) begin
            case (addr_i)
                REG_STATUS: begin
                    ovr_d  = ovr_q & ~wdata_i[STAT_OVERRUN];
                    perr_d = perr_q & ~wdata_i[STAT_PAR_ERR];
                end
                REG_CTRL: begin
                    en_d     = wdata_i[CTRL_EN];
                    irq_en_d = wdata_i[CTRL_IRQ_EN];
                end
                REG_THRESH: begin
                    if (wdata_i == '0)          thresh_d = CW'(1);
                    else if (wdata_i > DEPTH_W) thresh_d = CW'(DEPTH);
                    else                        thresh_d = wdata_i[CW-1:0];
                end
                default: ;
            endcase
        end
        // Setting events come last so they win over a same-cycle W1C.
        if (push & fifo_full & ~pop & ~flush) ovr_d = 1'b1;
`ifdef UART_RX_CTRL_PARITY_EN
        if (push & ((^rx_data_i[7:0]) ^ par_q)) perr_d = 1'b1;
`endif
        irq_d = irq_en_q & ((fifo_cnt >= thresh_q) | ovr_q | perr_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            thresh_q <= CW'(1);
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: register table, hand-written corner sequences, then random traffic vs a queue model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
`ifdef UART_RX_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [31:0] A_DATA = 32'h00, A_STAT = 32'h04, A_CNT = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_THR = 32'h10;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [31:0] rdata_o, rx_addr_o, rx_data_i;
    logic        irq_o, rx_req_o, rx_we_o;

    int n_checks = 0;
    int n_errors = 0;

    // uart_rx model: a byte is pending while more were offered than read out.
    int          m_sent = 0;
    int          m_taken = 0;
    logic        m_valid;
    logic [7:0]  m_data = '0;
    logic        m_par = 1'b0;

    // Reference model of the controller's observable state.
    byte unsigned q[$];
    bit          ovr, perr, irq_en;
    int          eff_th;

    vec_t        vec[17];
    logic [31:0] d, last;
    int          lat, op, w;
    logic [7:0]  b;
    logic        p;

    always #5 clk = ~clk;

    assign m_valid   = (m_sent != m_taken);
    assign rx_data_i = (rx_addr_o == 32'h4)  ? {31'b0, m_valid} :
                       (rx_addr_o == 32'h10) ? {31'b0, m_par}   : {24'b0, m_data};

    always @(posedge clk) begin
        if (rst_ni && rx_req_o && rx_addr_o == 32'h0) m_taken = m_taken + 1;
    end

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o), .rx_req_o(rx_req_o),
        .rx_we_o(rx_we_o), .rx_addr_o(rx_addr_o), .rx_data_i(rx_data_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Bus tasks start on a negedge and return on the next one.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] dat);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk);
        req_i = 1'b0;
        dat = rdata_o;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = wd;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_read(a, r);
        check(name, r, exp);
    endtask

    function automatic logic [31:0] exp_status();
        return {28'b0, perr, ovr, q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic logic exp_irq();
        return irq_en && ((q.size() >= eff_th) || ovr || perr);
    endfunction

    task automatic model_reset();
        q.delete();
        ovr = 0; perr = 0; irq_en = 0; eff_th = 1;
    endtask

    task automatic model_push(input logic [7:0] bt, input logic pb);
        if (PAR && ((^bt) ^ pb)) perr = 1;
        if (q.size() < DEPTH) q.push_back(bt);
        else ovr = 1;
    endtask

    task automatic offer(input logic [7:0] bt, input logic pb);
        m_data = bt; m_par = pb; m_sent++;
    endtask

    task automatic wait_taken(output int k);
        k = 0;
        while (m_taken != m_sent && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (m_taken != m_sent) timeout("wait_taken");
    endtask

    task automatic wait_rx_addr(input logic [31:0] a);
        int k = 0;
        while (!(rx_req_o && rx_addr_o == a) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!(rx_req_o && rx_addr_o == a)) timeout("wait_rx_addr");
    endtask

    task automatic send_model(input logic [7:0] bt, input logic pb);
        int k;
        offer(bt, pb);
        wait_taken(k);
        model_push(bt, pb);
    endtask

    task automatic read_data_check(input string name);
        logic [31:0] e;
        e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'h0;
        rd_check(name, A_DATA, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{1'b0, A_STAT, 32'h0, 32'h1};
        vec[1]  = '{1'b0, A_CNT,  32'h0, 32'h0};
        vec[2]  = '{1'b0, A_CTRL, 32'h0, 32'h1};
        vec[3]  = '{1'b0, A_THR,  32'h0, 32'h1};
        vec[4]  = '{1'b0, A_DATA, 32'h0, 32'h0};
        vec[5]  = '{1'b0, 32'h14, 32'h0, 32'h0};
        vec[6]  = '{1'b1, A_THR,  32'h5, 32'h0};
        vec[7]  = '{1'b0, A_THR,  32'h0, 32'h5};
        vec[8]  = '{1'b1, A_CTRL, 32'h3, 32'h0};
        vec[9]  = '{1'b0, A_CTRL, 32'h0, 32'h3};
        vec[10] = '{1'b1, 32'h14, 32'hFFFF_FFFF, 32'h0};
        vec[11] = '{1'b0, 32'h14, 32'h0, 32'h0};
        vec[12] = '{1'b1, A_CTRL, 32'h5, 32'h0};
        vec[13] = '{1'b0, A_CTRL, 32'h0, 32'h1};
        vec[14] = '{1'b1, A_THR,  32'h1, 32'h0};
        vec[15] = '{1'b1, A_STAT, 32'hF, 32'h0};
        vec[16] = '{1'b0, A_STAT, 32'h0, 32'h1};
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_irq", irq_o, 32'h0);
        check("rst_rx_req", rx_req_o, 32'h0);
        check("rst_rx_addr", rx_addr_o, 32'h0);
        check("rst_rx_we", rx_we_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Register table: reads check rdata, writes check that rdata holds.
        last = '0;
        for (int i = 0; i < 17; i++) begin
            if (vec[i].we) begin
                bus_write(vec[i].addr, vec[i].wdata);
                check($sformatf("vec%0d_hold", i), rdata_o, last);
            end else begin
                bus_read(vec[i].addr, d);
                check($sformatf("vec%0d_rd", i), d, vec[i].exp);
                last = vec[i].exp;
            end
            @(negedge clk);
            check($sformatf("vec%0d_irq", i), irq_o, 32'h0);
        end

        // Single byte and valid-to-push latency.
        offer(8'hA5, ^8'hA5);
        wait_taken(lat);
        model_push(8'hA5, ^8'hA5);
        check("push_latency", 32'(lat), PAR ? 32'd3 : 32'd2);
        rd_check("a5_count", A_CNT, 32'd1);
        rd_check("a5_data", A_DATA, 32'h0000_00A5);
        void'(q.pop_front());
        rd_check("a5_count_after", A_CNT, 32'd0);

        // Overflow with 17 bytes, then W1C overrun.
        for (int i = 0; i < 17; i++) send_model(8'(i + 16), ^(8'(i + 16)));
        rd_check("ovf_count", A_CNT, 32'd16);
        rd_check("ovf_status", A_STAT, exp_status());
        bus_write(A_STAT, 32'h4);
        ovr = 0;
        rd_check("ovf_w1c", A_STAT, exp_status());

        // Pop and push in the same cycle while full.
        offer(8'h77, ^8'h77);
        wait_rx_addr(32'h0);
        bus_read(A_DATA, d);
        check("fullpp_data", d, {24'b0, q.pop_front()});
        q.push_back(8'h77);
        rd_check("fullpp_count", A_CNT, 32'd16);
        rd_check("fullpp_status", A_STAT, exp_status());
        for (int i = 0; i < 16; i++) read_data_check($sformatf("drain%0d", i));
        rd_check("drain_status", A_STAT, exp_status());

        // Threshold interrupt timing and THRESH clamping.
        bus_write(A_CTRL, 32'h3); irq_en = 1;
        bus_write(A_THR, 32'h4);  eff_th = 4;
        for (int i = 0; i < 3; i++) send_model(8'(i + 1), ^(8'(i + 1)));
        @(negedge clk);
        check("irq_below", irq_o, exp_irq());
        send_model(8'h04, ^8'h04);
        check("irq_lag", irq_o, 32'h0);
        @(negedge clk);
        check("irq_rise", irq_o, 32'h1);
        read_data_check("irq_pop");
        check("irq_hold", irq_o, 32'h1);
        @(negedge clk);
        check("irq_fall", irq_o, exp_irq());
        bus_write(A_THR, 32'h0); eff_th = 1;
        @(negedge clk);
        check("irq_thr0", irq_o, exp_irq());
        bus_write(A_THR, 32'd100); eff_th = DEPTH;
        @(negedge clk);
        check("irq_thr_sat", irq_o, exp_irq());

        // Parity error on 0x03 with parity bit 1.
        send_model(8'h03, 1'b1);
        rd_check("par_status", A_STAT, exp_status());
        @(negedge clk);
        check("par_irq", irq_o, exp_irq());
        bus_write(A_STAT, 32'h8); perr = 0;
        rd_check("par_w1c", A_STAT, exp_status());
        for (int n = q.size(), i = 0; i < n; i++) read_data_check("par_drain");

        // Flush at the edge that pushes a byte.
        offer(8'h5A, ^8'h5A);
        wait_rx_addr(32'h0);
        bus_write(A_CTRL, 32'h7);
        q.delete();
        rd_check("flush_count", A_CNT, 32'd0);
        rd_check("flush_status", A_STAT, exp_status());

        // Reset in the middle of a receive sequence.
        bus_write(A_THR, 32'h1); eff_th = 1;
        send_model(8'h11, ^8'h11);
        rd_check("prerst_count", A_CNT, 32'd1);
        @(negedge clk);
        check("prerst_irq", irq_o, 32'h1);
        offer(8'h22, ^8'h22);
        wait_rx_addr(PAR ? 32'h10 : 32'h0);
        rst_ni = 1'b0;
        @(negedge clk);
        check("midrst_rdata", rdata_o, 32'h0);
        check("midrst_irq", irq_o, 32'h0);
        check("midrst_rx_req", rx_req_o, 32'h0);
        check("midrst_rx_addr", rx_addr_o, 32'h0);
        rst_ni = 1'b1;
        model_reset();
        wait_taken(lat);
        model_push(8'h22, ^8'h22);
        rd_check("reread_count", A_CNT, 32'd1);
        read_data_check("reread_data");

        // Random traffic against the model.
        bus_write(A_CTRL, 32'h3); irq_en = 1;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1: begin
                    b = 8'($urandom);
                    p = 1'($urandom);
                    send_model(b, p);
                end
                2: read_data_check("rnd_data");
                3: rd_check("rnd_count", A_CNT, 32'(q.size()));
                4: rd_check("rnd_status", A_STAT, exp_status());
                5: begin
                    w = $urandom_range(0, 15);
                    bus_write(A_STAT, 32'(w));
                    if (w[2]) ovr = 0;
                    if (w[3]) perr = 0;
                end
                default: begin
                    w = $urandom_range(0, 20);
                    bus_write(A_THR, 32'(w));
                    eff_th = (w == 0) ? 1 : (w > DEPTH) ? DEPTH : w;
                end
            endcase
            @(negedge clk);
            check("rnd_irq", irq_o, exp_irq());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
